// File: rtl/mant_align_if.sv
// mant_align_if: operand/result bundle for the mantissa alignment stage.
//   Operand side : in_valid/out_ready handshake, comparator verdict, bigger
//                  exponent, exponent difference, signs and significands.
//   Result side  : out_valid/in_ready handshake, aligned significands with
//                  G/R/S bits, exponent, signs ordered by magnitude, swap flag.
// master = whoever supplies operands and consumes results; slave = mant_align.
interface mant_align_if #(
  parameter int EXP_WIDTH  = 11,
  parameter int MANT_WIDTH = 53
);
  logic                  in_valid;
  logic                  out_ready;
  logic                  in_result;
  logic [EXP_WIDTH-1:0]  in_biggerExp;
  logic [EXP_WIDTH-1:0]  in_diff;
  logic                  in_signA;
  logic                  in_signB;
  logic [MANT_WIDTH-1:0] in_mantA;
  logic [MANT_WIDTH-1:0] in_mantB;

  logic                  out_valid;
  logic                  in_ready;
  logic [MANT_WIDTH+2:0] out_mantBig;
  logic [MANT_WIDTH+2:0] out_mantSmall;
  logic [EXP_WIDTH-1:0]  out_exp;
  logic                  out_signBig;
  logic                  out_signSmall;
  logic                  out_swapped;

  modport slave (
    input  in_valid, in_result, in_biggerExp, in_diff, in_signA, in_signB,
           in_mantA, in_mantB, in_ready,
    output out_ready, out_valid, out_mantBig, out_mantSmall, out_exp,
           out_signBig, out_signSmall, out_swapped
  );

  modport master (
    output in_valid, in_result, in_biggerExp, in_diff, in_signA, in_signB,
           in_mantA, in_mantB, in_ready,
    input  out_ready, out_valid, out_mantBig, out_mantSmall, out_exp,
           out_signBig, out_signSmall, out_swapped
  );
endinterface

// File: rtl/mant_align.sv
// mant_align: two-stage significand alignment ahead of an FP adder.
//   S1 captures an operand set, orders the significands by magnitude using the
//   comparator verdict and saturates the shift amount. S2 appends G/R/S bits
//   and right-shifts the smaller significand, folding lost bits into sticky.
// Ports:
//   in_clk   - clock, all state on rising edge
//   in_rst_n - asynchronous active-low reset
//   bus      - mant_align_if.slave: operand handshake in, result handshake out
// Latency 2 cycles, one set per cycle, full backpressure via a skid-free
// ready chain (out_ready depends only on pipeline state and in_ready).
module mant_align #(
  parameter int EXP_WIDTH  = 11,
  parameter int MANT_WIDTH = 53
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  mant_align_if.slave  bus
);
  localparam int W    = MANT_WIDTH + 3;
  localparam int SH_W = $clog2(W + 1);

  logic s1_load, s2_load, accept;
  logic [2:1] vld_pipe_q, vld_pipe_d;

  // S1 state
  logic [MANT_WIDTH-1:0] big_q, big_d, small_q, small_d;
  logic                  sgn_big_q, sgn_big_d, sgn_small_q, sgn_small_d;
  logic                  swap_q, swap_d;
  logic [EXP_WIDTH-1:0]  exp_q, exp_d;
  logic [SH_W-1:0]       shift_q, shift_d;

  // S2 state (drives the outputs directly)
  logic [W-1:0]          obig_q, obig_d, osmall_q, osmall_d;
  logic [EXP_WIDTH-1:0]  oexp_q, oexp_d;
  logic                  osgn_big_q, osgn_big_d, osgn_small_q, osgn_small_d;
  logic                  oswap_q, oswap_d;

  // Alignment datapath
  logic [2*W-1:0]        sh_ext;
  logic [W-1:0]          sh_kept;
  logic                  sticky;

  always_comb begin
    s2_load = !vld_pipe_q[2] || bus.in_ready;
    s1_load = !vld_pipe_q[1] || s2_load;
    accept  = bus.in_valid && s1_load;
    vld_pipe_d[1] = s1_load ? accept : vld_pipe_q[1];
    vld_pipe_d[2] = s2_load ? vld_pipe_q[1] : vld_pipe_q[2];
  end

  // S1: swap by comparator verdict, saturate shift at the full extended width
  // (anything wider leaves only sticky). Data inputs are looked at only on accept.
  always_comb begin
    big_d       = big_q;
    small_d     = small_q;
    sgn_big_d   = sgn_big_q;
    sgn_small_d = sgn_small_q;
    swap_d      = swap_q;
    exp_d       = exp_q;
    shift_d     = shift_q;
    if (accept) begin
      big_d       = bus.in_result ? bus.in_mantB : bus.in_mantA;
      small_d     = bus.in_result ? bus.in_mantA : bus.in_mantB;
      sgn_big_d   = bus.in_result ? bus.in_signB : bus.in_signA;
      sgn_small_d = bus.in_result ? bus.in_signA : bus.in_signB;
      swap_d      = bus.in_result;
      exp_d       = bus.in_biggerExp;
      if (32'(bus.in_diff) >= 32'(W)) shift_d = SH_W'(W);
      else                             shift_d = SH_W'(bus.in_diff);
    end
  end

  // S2: shift {small,GRS} into the upper half of a double-width word; whatever
  // lands in the lower half was shifted out and collapses into the sticky bit.
  always_comb begin
    sh_ext  = {small_q, 3'b000, {W{1'b0}}} >> shift_q;
    sh_kept = sh_ext[2*W-1:W];
    sticky  = |sh_ext[W-1:0];
  end

  always_comb begin
    obig_d       = obig_q;
    osmall_d     = osmall_q;
    oexp_d       = oexp_q;
    osgn_big_d   = osgn_big_q;
    osgn_small_d = osgn_small_q;
    oswap_d      = oswap_q;
    if (s2_load && vld_pipe_q[1]) begin
      obig_d       = {big_q, 3'b000};
      osmall_d     = {sh_kept[W-1:1], sh_kept[0] | sticky};
      oexp_d       = exp_q;
      osgn_big_d   = sgn_big_q;
      osgn_small_d = sgn_small_q;
      oswap_d      = swap_q;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      vld_pipe_q   <= '0;
      big_q        <= '0;
      small_q      <= '0;
      sgn_big_q    <= 1'b0;
      sgn_small_q  <= 1'b0;
      swap_q       <= 1'b0;
      exp_q        <= '0;
      shift_q      <= '0;
      obig_q       <= '0;
      osmall_q     <= '0;
      oexp_q       <= '0;
      osgn_big_q   <= 1'b0;
      osgn_small_q <= 1'b0;
      oswap_q      <= 1'b0;
    end else begin
      vld_pipe_q   <= vld_pipe_d;
      big_q        <= big_d;
      small_q      <= small_d;
      sgn_big_q    <= sgn_big_d;
      sgn_small_q  <= sgn_small_d;
      swap_q       <= swap_d;
      exp_q        <= exp_d;
      shift_q      <= shift_d;
      obig_q       <= obig_d;
      osmall_q     <= osmall_d;
      oexp_q       <= oexp_d;
      osgn_big_q   <= osgn_big_d;
      osgn_small_q <= osgn_small_d;
      oswap_q      <= oswap_d;
    end
  end

  assign bus.out_ready     = s1_load;
  assign bus.out_valid     = vld_pipe_q[2];
  assign bus.out_mantBig   = obig_q;
  assign bus.out_mantSmall = osmall_q;
  assign bus.out_exp       = oexp_q;
  assign bus.out_signBig   = osgn_big_q;
  assign bus.out_signSmall = osgn_small_q;
  assign bus.out_swapped   = oswap_q;
endmodule

// File: tb/tb_mant_align.sv
module tb_mant_align;
  logic in_clk = 1'b0;
  logic in_rst_n;

  mant_align_if #(.EXP_WIDTH(11), .MANT_WIDTH(53)) bus ();
  mant_align dut (.in_clk(in_clk), .in_rst_n(in_rst_n), .bus(bus));

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [55:0] mb;
    logic [55:0] ms;
    logic [10:0] ex;
    logic        sb;
    logic        ss;
    logic        sw;
  } exp_t;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h want %h @%0t", name, act, req, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid     = 1'b0;
    bus.in_result    = 1'bx;
    bus.in_biggerExp = 'x;
    bus.in_diff      = 'x;
    bus.in_signA     = 1'bx;
    bus.in_signB     = 1'bx;
    bus.in_mantA     = 'x;
    bus.in_mantB     = 'x;
  endtask

  // Present one set, push its hand-computed result when it is accepted.
  // Expected signs given directly as big/small.
  task automatic send(input logic res, input logic [10:0] bexp, input logic [10:0] diff,
                      input logic sa, input logic sb,
                      input logic [52:0] ma, input logic [52:0] mb,
                      input logic [55:0] emb, input logic [55:0] ems,
                      input logic esb, input logic ess);
    exp_t e;
    int t;
    bus.in_valid     = 1'b1;
    bus.in_result    = res;
    bus.in_biggerExp = bexp;
    bus.in_diff      = diff;
    bus.in_signA     = sa;
    bus.in_signB     = sb;
    bus.in_mantA     = ma;
    bus.in_mantB     = mb;
    e.mb = emb; e.ms = ems; e.ex = bexp; e.sb = esb; e.ss = ess; e.sw = res;
    t = 0;
    @(negedge in_clk);
    while (!bus.out_ready && t < 200) begin
      @(negedge in_clk);
      t++;
    end
    if (!bus.out_ready) check("accept_timeout", 64'd0, 64'd1);
    else sbq.push_back(e);
    @(posedge in_clk);
    #1;
    idle_inputs();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge in_clk);
      t++;
    end
    repeat (2) @(negedge in_clk);
    check("drain", 64'(sbq.size()), 64'd0);
  endtask

  // Scoreboard monitor: whenever a result is presented, compare to the head;
  // pop only when it is actually consumed, so held data is rechecked each stall cycle.
  exp_t me;
  always @(negedge in_clk) begin
    if (in_rst_n && bus.out_valid) begin
      if (sbq.size() == 0) check("unexpected_out", 64'd1, 64'd0);
      else begin
        me = sbq[0];
        check("mantBig",   64'(bus.out_mantBig),   64'(me.mb));
        check("mantSmall", 64'(bus.out_mantSmall), 64'(me.ms));
        check("exp",       64'(bus.out_exp),       64'(me.ex));
        check("signBig",   64'(bus.out_signBig),   64'(me.sb));
        check("signSmall", 64'(bus.out_signSmall), 64'(me.ss));
        check("swapped",   64'(bus.out_swapped),   64'(me.sw));
        if (bus.in_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    in_rst_n     = 1'b0;
    bus.in_ready = 1'b1;
    idle_inputs();
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ready", 64'(bus.out_ready), 64'd1);
    repeat (3) @(posedge in_clk);
    #1 in_rst_n = 1'b1;
    repeat (2) @(negedge in_clk);
    check("idle_valid",   64'(bus.out_valid),     64'd0);
    check("idle_ready",   64'(bus.out_ready),     64'd1);
    check("idle_mantBig", 64'(bus.out_mantBig),   64'd0);
    check("idle_mantSm",  64'(bus.out_mantSmall), 64'd0);
    check("idle_exp",     64'(bus.out_exp),       64'd0);

    // A bigger, diff 3, no bits lost; also check the 2-cycle latency
    @(posedge in_clk); #1;
    send(1'b0, 11'h400, 11'd3, 1'b0, 1'b1, 53'h18000000000000, 53'h10000000000003,
         56'hC0000000000000, 56'h10000000000003, 1'b0, 1'b1);
    @(negedge in_clk);
    check("lat_c1_valid", 64'(bus.out_valid), 64'd0);
    @(negedge in_clk);
    check("lat_c2_valid", 64'(bus.out_valid), 64'd1);
    drain();

    @(posedge in_clk); #1;
    // B bigger, diff 60 saturates -> sticky only
    send(1'b1, 11'h3FF, 11'd60, 1'b1, 1'b0, 53'h1FFFFFFFFFFFFF, 53'h10000000000000,
         56'h80000000000000, 56'h00000000000001, 1'b0, 1'b1);
    // diff 0, equal significands
    send(1'b0, 11'h123, 11'd0, 1'b0, 1'b0, 53'h10000000000001, 53'h10000000000001,
         56'h80000000000008, 56'h80000000000008, 1'b0, 1'b0);
    // diff 5, a set bit falls off the end -> sticky sets LSB
    send(1'b0, 11'h055, 11'd5, 1'b1, 1'b1, 53'h1FFFFFFFFFFFFF, 53'h10000000000001,
         56'hFFFFFFFFFFFFF8, 56'h04000000000001, 1'b1, 1'b1);
    // diff 55, hidden bit lands exactly in the LSB, nothing lost
    send(1'b1, 11'h7FE, 11'd55, 1'b0, 1'b1, 53'h10000000000000, 53'h10000000000000,
         56'h80000000000000, 56'h00000000000001, 1'b1, 1'b0);
    // diff 56 (exact saturation) with zero small -> zero, no sticky
    send(1'b0, 11'h001, 11'd56, 1'b0, 1'b1, 53'h10000000000000, 53'h00000000000000,
         56'h80000000000000, 56'h00000000000000, 1'b0, 1'b1);
    // both zero, small shift
    send(1'b1, 11'h000, 11'd2, 1'b1, 1'b0, 53'h0, 53'h0,
         56'h0, 56'h0, 1'b0, 1'b1);
    drain();

    // Back-to-back stream with a 3-cycle downstream stall
    @(posedge in_clk); #1;
    fork
      begin
        send(1'b0, 11'h010, 11'd0, 1'b0, 1'b1, 53'h11, 53'h22, 56'h88,  56'h110, 1'b0, 1'b1);
        send(1'b1, 11'h011, 11'd1, 1'b1, 1'b0, 53'h01, 53'h40, 56'h200, 56'h4,   1'b0, 1'b1);
        send(1'b0, 11'h012, 11'd2, 1'b1, 1'b1, 53'h07, 53'h03, 56'h38,  56'h6,   1'b1, 1'b1);
        send(1'b1, 11'h013, 11'd3, 1'b0, 1'b0, 53'h05, 53'h09, 56'h48,  56'h5,   1'b0, 1'b0);
      end
      begin
        int t;
        t = 0;
        do begin
          @(posedge in_clk); #1;
          t++;
        end while (!bus.out_valid && t < 50);
        check("stream_first_valid", 64'(bus.out_valid), 64'd1);
        bus.in_ready = 1'b0;
        repeat (3) begin
          @(negedge in_clk);
          check("stall_ready", 64'(bus.out_ready), 64'd0);
          check("stall_valid", 64'(bus.out_valid), 64'd1);
        end
        @(posedge in_clk); #1;
        bus.in_ready = 1'b1;
      end
    join
    drain();

    // Fill both stages, then reset: in-flight sets must vanish
    @(posedge in_clk); #1;
    bus.in_ready = 1'b0;
    send(1'b0, 11'h111, 11'd1, 1'b0, 1'b0, 53'h3, 53'h2, 56'h18, 56'h8, 1'b0, 1'b0);
    send(1'b0, 11'h222, 11'd1, 1'b0, 1'b0, 53'h5, 53'h4, 56'h28, 56'h10, 1'b0, 1'b0);
    @(negedge in_clk);
    check("full_ready", 64'(bus.out_ready), 64'd0);
    check("full_valid", 64'(bus.out_valid), 64'd1);
    #2 in_rst_n = 1'b0;
    #1;
    check("arst_valid",   64'(bus.out_valid),   64'd0);
    check("arst_ready",   64'(bus.out_ready),   64'd1);
    check("arst_mantBig", 64'(bus.out_mantBig), 64'd0);
    sbq.delete();
    @(posedge in_clk); #1;
    in_rst_n     = 1'b1;
    bus.in_ready = 1'b1;
    send(1'b1, 11'h333, 11'd4, 1'b0, 1'b1, 53'h10, 53'h20, 56'h100, 56'h8, 1'b1, 1'b0);
    drain();
    repeat (4) @(negedge in_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
